// File: rtl/nyq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nyq_pkg
// Description : Shared constants, width helpers and the round/saturate
//               function for the polyphase Nyquist decimator.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents:
//   NYQ_MAX_W        working width of the round/saturate helper
//   CTRL_*_BIT       bit positions inside the CTRL word
//   clog2()          ceil(log2(value)), 0 for value <= 1
//   acc_width()      accumulator width with no internal overflow
//   ctrl_addr()      CTRL word address (top of the parameter memory)
//   round_sat()      round-half-up shift, then clip to a signed output range
// ============================================================================
package nyq_pkg;

  localparam int NYQ_MAX_W = 128;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_BYPASS_BIT  = 1;
  localparam int CTRL_SAT_CLR_BIT = 2;

  typedef struct packed {
    logic signed [NYQ_MAX_W-1:0] val;
    logic                        sat;
  } nyq_rs_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int in_w, input int coef_w, input int taps);
    return in_w + coef_w + clog2(taps);
  endfunction

  function automatic int ctrl_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  // Adds half an LSB of the result before the arithmetic shift (round half
  // up); frac = 0 passes the value unchanged into the clip stage.
  function automatic nyq_rs_t round_sat(input logic signed [NYQ_MAX_W-1:0] acc,
                                        input int frac,
                                        input int out_w);
    logic signed [NYQ_MAX_W-1:0] one;
    logic signed [NYQ_MAX_W-1:0] rnd;
    logic signed [NYQ_MAX_W-1:0] r;
    logic signed [NYQ_MAX_W-1:0] maxv;
    logic signed [NYQ_MAX_W-1:0] minv;
    nyq_rs_t res;
    one  = NYQ_MAX_W'(1);
    rnd  = (frac > 0) ? (one <<< (frac - 1)) : '0;
    r    = (acc + rnd) >>> frac;
    maxv = (one <<< (out_w - 1)) - one;
    minv = -maxv - one;
    res.sat = 1'b1;
    if (r > maxv) begin
      res.val = maxv;
    end else if (r < minv) begin
      res.val = minv;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nyq_polyphase_decim_mac_stage.sv
`default_nettype none
// ============================================================================
// Module      : nyq_mac_stage
// Description : One polyphase stage: multiplier, accumulator A_j and the
//               stage delay register Dl_j that carries partial block sums
//               towards the output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clk_CI       clock, rising edge
//   Rst_RBI      asynchronous active-low reset
//   Flush_SI     synchronous clear of accumulator and delay
//   Accept_SI    sample X_DI is accepted this cycle
//   BlockEnd_SI  accepted sample is the last of a block (k = DEC-1)
//   Bypass_SI    filter skipped, accumulator held at zero
//   X_DI         input sample (two's complement)
//   Coef_DI      coefficient h[j*DEC + DEC-1-k] (two's complement)
//   ChainIn_DI   Dl_{j+1} (zero for the last stage)
//   ChainOut_DO  Dl_j, or for the first stage (no delay) the block result
//                A_0' + Dl_1 as a combinational value
// ============================================================================
module nyq_mac_stage #(
  parameter int IN_WIDTH   = 24,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 45,
  parameter bit HAS_DL     = 1'b1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Flush_SI,
  input  logic                  Accept_SI,
  input  logic                  BlockEnd_SI,
  input  logic                  Bypass_SI,
  input  logic [IN_WIDTH-1:0]   X_DI,
  input  logic [COEF_WIDTH-1:0] Coef_DI,
  input  logic [ACC_WIDTH-1:0]  ChainIn_DI,
  output logic [ACC_WIDTH-1:0]  ChainOut_DO
);

  localparam int PROD_W = IN_WIDTH + COEF_WIDTH;

  logic [PROD_W-1:0]    w_x_ext;
  logic [PROD_W-1:0]    w_c_ext;
  logic [PROD_W-1:0]    w_prod;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] r_acc;

  // Both operands are sign-extended to the full product width, so the low
  // PROD_W bits of the unsigned product are the exact signed product.
  assign w_x_ext    = {{COEF_WIDTH{X_DI[IN_WIDTH-1]}}, X_DI};
  assign w_c_ext    = {{IN_WIDTH{Coef_DI[COEF_WIDTH-1]}}, Coef_DI};
  assign w_prod     = w_x_ext * w_c_ext;
  assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;
  assign w_sum      = w_acc_next + ChainIn_DI;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_acc <= '0;
    end else if (Flush_SI || Bypass_SI) begin
      r_acc <= '0;
    end else if (Accept_SI) begin
      r_acc <= BlockEnd_SI ? '0 : w_acc_next;
    end
  end

  generate
    if (HAS_DL) begin : g_dl
      logic [ACC_WIDTH-1:0] r_dl;
      always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
          r_dl <= '0;
        end else if (Flush_SI) begin
          r_dl <= '0;
        end else if (Accept_SI && BlockEnd_SI && !Bypass_SI) begin
          r_dl <= w_sum;
        end
      end
      assign ChainOut_DO = r_dl;
    end else begin : g_no_dl
      assign ChainOut_DO = w_sum;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/nyq_polyphase_decim.sv
`default_nettype none
// ============================================================================
// Module      : nyq_polyphase_decim
// Description : Polyphase Nyquist decimator. TAPS = DEC*PHASES tap FIR, one
//               rounded/saturated output per DEC accepted input samples.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Clk_CI          clock, rising edge
//   Rst_RBI         asynchronous active-low reset
//   WrEn_SI         parameter write enable
//   Addr_DI         parameter address (h[n] at n, CTRL at MEM_DEPTH-1)
//   PAR_In_DI       parameter data
//   NYQ_In_DI       signed input sample
//   NYQ_InValid_SI  input sample valid
//   NYQ_Out_DO      signed decimated output (held between pulses)
//   NYQ_Valid_DO    one-cycle pulse on new output
//   NYQ_Sat_SO      sticky saturation flag
// ============================================================================
module nyq_polyphase_decim
  import nyq_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_WIDTH  = 32,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_WIDTH = 16,
  parameter int DEC        = 8,
  parameter int PHASES     = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
  input  logic [IN_WIDTH-1:0]   NYQ_In_DI,
  input  logic                  NYQ_InValid_SI,
  output logic [OUT_WIDTH-1:0]  NYQ_Out_DO,
  output logic                  NYQ_Valid_DO,
  output logic                  NYQ_Sat_SO
);

  localparam int TAPS  = DEC * PHASES;
  localparam int KW    = clog2(DEC);
  localparam int TW    = clog2(TAPS);
  localparam int ACC_W = acc_width(IN_WIDTH, COEF_WIDTH, TAPS);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(ctrl_addr(ADDR_WIDTH));

  logic [COEF_WIDTH-1:0] r_coef [TAPS];
  logic                  r_en;
  logic                  r_byp;
  logic [KW-1:0]         r_k;
  logic [KW-1:0]         w_kinv;
  logic [ACC_W-1:0]      r_y;
  logic                  r_y_vld;
  logic                  r_y_byp;
  logic [OUT_WIDTH-1:0]  r_out;
  logic                  r_valid;
  logic                  r_sat;

  logic                  w_flush;
  logic                  w_coef_wr;
  logic                  w_accept;
  logic                  w_block_end;
  logic [ACC_W-1:0]      w_y;
  logic [ACC_W-1:0]      w_x_ext;
  logic [NYQ_MAX_W-1:0]  w_y_max;
  nyq_rs_t               w_rs;
  logic [ACC_W-1:0]      w_dl [1:PHASES];
  logic                  w_unused_ok;

  assign w_flush     = WrEn_SI && (Addr_DI == CTRL_ADDR);
  assign w_coef_wr   = WrEn_SI && (32'(Addr_DI) < 32'(TAPS));
  // A sample arriving together with a CTRL write is dropped by the flush.
  assign w_accept    = NYQ_InValid_SI && r_en && !w_flush;
  assign w_block_end = (r_k == KW'(DEC - 1));
  // DEC is a power of two, so DEC-1-k is the bitwise inverse of k.
  assign w_kinv      = ~r_k;
  assign w_x_ext     = {{(ACC_W-IN_WIDTH){NYQ_In_DI[IN_WIDTH-1]}}, NYQ_In_DI};
  assign w_dl[PHASES] = '0;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[Addr_DI[TW-1:0]] <= PAR_In_DI[COEF_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_en  <= 1'b0;
      r_byp <= 1'b0;
      r_k   <= '0;
    end else if (w_flush) begin
      r_en  <= PAR_In_DI[CTRL_EN_BIT];
      r_byp <= PAR_In_DI[CTRL_BYPASS_BIT];
      r_k   <= '0;
    end else if (w_accept) begin
      r_k   <= r_k + KW'(1);
    end
  end

  for (genvar j = 0; j < PHASES; j++) begin : g_stage
    logic [TW-1:0] w_idx;
    assign w_idx = TW'(j * DEC) | TW'(w_kinv);
    if (j == 0) begin : g_first
      nyq_mac_stage #(
        .IN_WIDTH   (IN_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_W),
        .HAS_DL     (1'b0)
      ) u_stage (
        .Clk_CI      (Clk_CI),
        .Rst_RBI     (Rst_RBI),
        .Flush_SI    (w_flush),
        .Accept_SI   (w_accept),
        .BlockEnd_SI (w_block_end),
        .Bypass_SI   (r_byp),
        .X_DI        (NYQ_In_DI),
        .Coef_DI     (r_coef[w_idx]),
        .ChainIn_DI  (w_dl[1]),
        .ChainOut_DO (w_y)
      );
    end else begin : g_rest
      nyq_mac_stage #(
        .IN_WIDTH   (IN_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_W),
        .HAS_DL     (1'b1)
      ) u_stage (
        .Clk_CI      (Clk_CI),
        .Rst_RBI     (Rst_RBI),
        .Flush_SI    (w_flush),
        .Accept_SI   (w_accept),
        .BlockEnd_SI (w_block_end),
        .Bypass_SI   (r_byp),
        .X_DI        (NYQ_In_DI),
        .Coef_DI     (r_coef[w_idx]),
        .ChainIn_DI  (w_dl[j+1]),
        .ChainOut_DO (w_dl[j])
      );
    end
  end

  // Block result is captured on the accepting edge; rounding and clipping
  // happen one edge later so the output register sits after them.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_y     <= '0;
      r_y_vld <= 1'b0;
      r_y_byp <= 1'b0;
    end else begin
      r_y_vld <= w_accept && w_block_end;
      if (w_accept && w_block_end) begin
        r_y     <= r_byp ? w_x_ext : w_y;
        r_y_byp <= r_byp;
      end
    end
  end

  assign w_y_max = {{(NYQ_MAX_W-ACC_W){r_y[ACC_W-1]}}, r_y};

  always_comb begin
    w_rs = round_sat(w_y_max, r_y_byp ? 0 : COEF_WIDTH - 1, OUT_WIDTH);
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= r_y_vld;
      if (r_y_vld) begin
        r_out <= w_rs.val[OUT_WIDTH-1:0];
      end
      if (w_flush && PAR_In_DI[CTRL_SAT_CLR_BIT]) begin
        r_sat <= 1'b0;
      end
      if (r_y_vld && w_rs.sat) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign NYQ_Out_DO   = r_out;
  assign NYQ_Valid_DO = r_valid;
  assign NYQ_Sat_SO   = r_sat;

  assign w_unused_ok = ^{PAR_In_DI, w_rs.val};

endmodule
`default_nettype wire
